// File: rtl/shift_deser.sv
// -----------------------------------------------------------------------------
// shift_deser -- serial-to-parallel receiver
//
// Collects nBit serial bits, MSB-first or LSB-first, and presents each
// assembled word on a valid/ready output port. The word is held until the
// consumer takes it. This block is the receive end of the parallel-load
// shift register when that register is used as a serial transmitter.
//
// All state updates on the falling edge of clk, like the datapath registers
// this block feeds.
//
// Optional build macro: SHIFT_DESER_PARITY_EN
//   Defined     : every frame has nBit data bits followed by one even-parity
//                 bit. Parity_Err reports a bad parity bit for the word that
//                 is currently on Output.
//   Not defined : a frame is nBit data bits. Parity_Err is always 0.
//
// Parameters:
//   nBit        data word width in bits (>= 2)
//
// Ports:
//   clk         clock (falling edge active)
//   clr_n       synchronous active-low reset
//   Start       frame start; discards any partial word
//   Msb_First   bit order for the frame starting now (1 = MSB-first)
//   Shift_In    serial data bit
//   Shift_Valid Shift_In is valid this cycle
//   Out_Ready   consumer accepts Output this cycle
//   Output      assembled word, held stable while Out_Valid = 1
//   Out_Valid   Output holds an unconsumed word
//   Busy        a frame is being collected
//   Overrun     sticky: a completed word was dropped
//   Parity_Err  parity result for the word on Output
// -----------------------------------------------------------------------------
module shift_deser #(
  parameter int nBit = 16
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            Start,
  input  logic            Msb_First,
  input  logic            Shift_In,
  input  logic            Shift_Valid,
  input  logic            Out_Ready,
  output logic [nBit-1:0] Output,
  output logic            Out_Valid,
  output logic            Busy,
  output logic            Overrun,
  output logic            Parity_Err
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME_LEN = nBit + 1;
`else
  localparam int FRAME_LEN = nBit;
`endif
  localparam int CW = $clog2(nBit + 2);
  // When cnt holds this value, the next valid bit is the last bit of the frame.
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [nBit-1:0] sr_reg, sr_next;
  logic [nBit-1:0] out_reg, out_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            ord_reg, ord_next;
  logic            valid_reg, valid_next;
  logic            ovr_reg, ovr_next;
  logic            perr_reg, perr_next;

  logic [nBit-1:0] shift_cur;   // SR shifted using the bit order latched for this frame
  logic [nBit-1:0] shift_new;   // SR shifted using the bit order of a frame starting now
  logic [nBit-1:0] word_done;   // word delivered when the frame completes
  logic            perr_done;   // parity result delivered when the frame completes
  logic            complete;    // this edge captures the final bit of the frame
  logic [CW-1:0]   restart_cnt; // count after Start: 1 if Start also carries a bit

  // MSB-first shifts left (new bit enters at bit 0). LSB-first shifts right
  // (new bit enters at the top), so the first bit received ends up in bit 0.
  function automatic logic [nBit-1:0] shift_bit(input logic [nBit-1:0] sr,
                                                input logic            msb,
                                                input logic            b);
    return msb ? {sr[nBit-2:0], b} : {b, sr[nBit-1:1]};
  endfunction

  always_comb begin
    shift_cur   = shift_bit(sr_reg, ord_reg, Shift_In);
    shift_new   = shift_bit(sr_reg, Msb_First, Shift_In);
    complete    = (state_reg == COLLECT) && Shift_Valid && (cnt_reg == LAST_IDX);
    restart_cnt = {{(CW-1){1'b0}}, Shift_Valid};
`ifdef SHIFT_DESER_PARITY_EN
    // The final bit is the parity bit. It is not shifted in, because SR
    // already holds all nBit data bits.
    word_done = sr_reg;
    perr_done = (^sr_reg) ^ Shift_In;
`else
    word_done = shift_cur;
    perr_done = 1'b0;
`endif
  end

  // Next-state and datapath logic
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    ord_next   = ord_reg;
    out_next   = out_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;
    perr_next  = perr_reg;

    case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next = COLLECT;
          ord_next   = Msb_First;
          cnt_next   = restart_cnt;
          if (Shift_Valid) sr_next = shift_new;
        end
      end
      COLLECT: begin
        if (complete) begin
          // The final bit belongs to the old frame, even if Start is also high.
          // A simultaneous Start only reopens collection with an empty count.
          sr_next  = word_done;
          cnt_next = '0;
          if (Start) begin
            ord_next = Msb_First;
          end else begin
            state_next = IDLE;
          end
        end else if (Start) begin
          ord_next = Msb_First;
          cnt_next = restart_cnt;
          if (Shift_Valid) sr_next = shift_new;
        end else if (Shift_Valid) begin
          sr_next  = shift_cur;
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Output port. The completing edge loads Output directly, so there is no
    // added latency. If the old word is being consumed on this same edge,
    // the new word takes its place. Otherwise the new word is dropped.
    if (complete) begin
      if (!valid_reg || Out_Ready) begin
        out_next   = word_done;
        perr_next  = perr_done;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end else if (valid_reg && Out_Ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      ord_reg   <= 1'b0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      ord_reg   <= ord_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
      perr_reg  <= perr_next;
    end
  end

  assign Output     = out_reg;
  assign Out_Valid  = valid_reg;
  assign Busy       = (state_reg == COLLECT);
  assign Overrun    = ovr_reg;
  assign Parity_Err = perr_reg;

endmodule
